// File: rtl/serv_mem_pkg.sv
// Shared types and helpers for the SERV bit-serial memory adapter.
// State encoding, access size codes, and per-size msb / lane-select / alignment helpers.
package serv_mem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShiftIn,
    StBus,
    StShiftOut
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Index of the most significant valid bit of a load of the given size.
  function automatic logic [4:0] size_msb(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 5'd7;
      SZ_HALF: return 5'd15;
      default: return 5'd31;
    endcase
  endfunction

  // Byte lanes touched by an access of the given size at the given address offset.
  function automatic logic [3:0] size_sel(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      SZ_BYTE: return 4'b0001 << lsb;
      SZ_HALF: return lsb[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Requests that cannot be issued: unaligned half/word, or the reserved size code.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lsb[0];
      SZ_WORD: return |lsb;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/serv_mem_ldser.sv
// Data register of the memory adapter plus the load-side serializer.
// Collects store bits one at a time, captures an aligned load word, and emits the
// extended load bit selected by the shared bit counter.
module serv_mem_ldser (
  input  logic        clk,
  input  logic        rst,
  input  logic        bit_wr,
  input  logic        bit_in,
  input  logic [4:0]  cnt,
  input  logic        word_wr,
  input  logic [31:0] word_in,
  input  logic [4:0]  msb,
  input  logic        sgn,
  output logic [31:0] data,
  output logic        ld
);

  // Data register: whole-word capture on load ack, single-bit writes while shifting in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
    end else if (word_wr) begin
      data <= word_in;
    end else if (bit_wr) begin
      data[cnt] <= bit_in;
    end
  end

  // Above the access msb the bit becomes the sign (or zero) extension.
  always_comb begin
    ld = 1'b0;
    if (cnt <= msb) begin
      ld = data[cnt];
    end else begin
      ld = sgn & data[msb];
    end
  end

endmodule

// File: rtl/serv_mem_serdes.sv
// Bit-serial memory data adapter between the SERV datapath and a 32-bit Wishbone bus.
// Stores shift a 32-bit operand in LSB first, then issue one replicated write; loads issue
// one read, then shift the aligned, extended result out LSB first.
// Optional bus timeout enabled by defining SERV_MEM_SERDES_TIMEOUT_EN.
module serv_mem_serdes
  import serv_mem_pkg::*;
#(
  parameter int unsigned TO_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_we,
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_lsb,
  input  logic        i_signed,
  input  logic        i_sd,
  input  logic        i_sd_en,
  output logic        o_ld,
  output logic        o_ld_en,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic        o_wb_cyc,
  output logic        o_wb_we,
  output logic [3:0]  o_wb_sel,
  output logic [31:0] o_wb_dat,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack
);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        we_q, sgn_q;
  logic [1:0]  size_q, lsb_q;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        bit_wr, word_wr;
  logic        ld_bit;
  logic [31:0] data;
  logic [31:0] rdt_aligned;
  logic [31:0] wdat;
  logic        in_bus;
  logic        to_hit;

`ifdef SERV_MEM_SERDES_TIMEOUT_EN
  logic [7:0] to_cnt_q;

  // Bus wait counter; held at zero outside BUS so every entry starts from zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      to_cnt_q <= '0;
    end else if (state_q == StBus) begin
      to_cnt_q <= to_cnt_q + 8'd1;
    end else begin
      to_cnt_q <= '0;
    end
  end

  // Last permitted bus cycle: give up if no ack arrives in it.
  assign to_hit = (to_cnt_q == 8'(TO_CYCLES - 1));
`else
  logic unused_to;
  assign unused_to = ^TO_CYCLES;
  assign to_hit    = 1'b0;
`endif

  assign in_bus      = (state_q == StBus);
  assign rdt_aligned = i_wb_rdt >> {lsb_q, 3'b000};

  serv_mem_ldser u_ldser (
    .clk     (i_clk),
    .rst     (i_rst),
    .bit_wr  (bit_wr),
    .bit_in  (i_sd),
    .cnt     (cnt_q),
    .word_wr (word_wr),
    .word_in (rdt_aligned),
    .msb     (size_msb(size_q)),
    .sgn     (sgn_q),
    .data    (data),
    .ld      (ld_bit)
  );

  // State, counter and completion pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Request attributes are captured only when a new request is accepted in IDLE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      we_q   <= 1'b0;
      size_q <= SZ_BYTE;
      lsb_q  <= '0;
      sgn_q  <= 1'b0;
    end else if ((state_q == StIdle) && i_start) begin
      we_q   <= i_we;
      size_q <= i_size;
      lsb_q  <= i_lsb;
      sgn_q  <= i_signed;
    end
  end

  // Next-state logic and data-register write strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    bit_wr  = 1'b0;
    word_wr = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          if (misaligned(i_size, i_lsb)) begin
            err_d = 1'b1;
          end else if (i_we) begin
            state_d = StShiftIn;
          end else begin
            state_d = StBus;
          end
        end
      end
      StShiftIn: begin
        if (i_sd_en) begin
          bit_wr = 1'b1;
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = StBus;
          end
        end
      end
      StBus: begin
        if (i_wb_ack) begin
          if (we_q) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            word_wr = 1'b1;
            state_d = StShiftOut;
          end
        end else if (to_hit) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StShiftOut: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Write data with the operand replicated across every lane it could land in.
  always_comb begin
    wdat = '0;
    if (in_bus) begin
      case (size_q)
        SZ_BYTE: wdat = {4{data[7:0]}};
        SZ_HALF: wdat = {2{data[15:0]}};
        default: wdat = data;
      endcase
    end
  end

  assign o_busy   = (state_q != StIdle);
  assign o_done   = done_q;
  assign o_err    = err_q;
  assign o_wb_cyc = in_bus;
  assign o_wb_we  = in_bus & we_q;
  assign o_wb_sel = in_bus ? size_sel(size_q, lsb_q) : 4'b0000;
  assign o_wb_dat = wdat;
  assign o_ld_en  = (state_q == StShiftOut);
  assign o_ld     = o_ld_en & ld_bit;

endmodule

// File: doc/serv_mem_serdes.md
Name: serv_mem_serdes

Overview:
Bit-serial memory data adapter between the SERV serial datapath and a 32-bit Wishbone data bus.
- Stores: collects a serial LSB-first operand into a 32-bit word, then issues one bus write with lane replication and byte selects.
- Loads: issues one bus read, then streams the aligned, sign- or zero-extended result back LSB-first, one bit per cycle.
- It is the serial-out/parallel-in counterpart to the core's serial shift logic and sits between the core datapath and the data bus arbiter.

Parameters:
- TO_CYCLES, 255: bus timeout limit in cycles; used only with the optional feature.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; asynchronous, active-high
- i_start  in  1  one-cycle request to begin a transaction
- i_we  in  1  1 = store, 0 = load (sampled with i_start)
- i_size  in  2  00 byte, 01 half, 10 word, 11 reserved (sampled with i_start)
- i_lsb  in  2  address bits [1:0] (sampled with i_start)
- i_signed  in  1  sign-extend load result (sampled with i_start)
- i_sd  in  1  serial store data bit, LSB first
- i_sd_en  in  1  i_sd valid this cycle
- o_ld  out  1  serial load data bit, LSB first
- o_ld_en  out  1  o_ld valid this cycle
- o_busy  out  1  FSM not in IDLE
- o_done  out  1  one-cycle completion pulse
- o_err  out  1  one-cycle error pulse (misaligned access, reserved size, or timeout)
- o_wb_cyc  out  1  Wishbone cycle/strobe
- o_wb_we  out  1  Wishbone write enable
- o_wb_sel  out  4  byte lane selects
- o_wb_dat  out  32  write data
- i_wb_rdt  in  32  read data
- i_wb_ack  in  1  Wishbone acknowledge

Behaviour:
- Reset (asynchronous, i_rst high):
  - State goes to IDLE; bit counter and data register clear to 0.
  - All outputs are 0, including o_wb_cyc, o_wb_sel, o_wb_dat, o_ld_en, o_done and o_err.
  - Reset asserted mid-transaction aborts it immediately; no o_done or o_err is issued.
- States: IDLE, SHIFT_IN, BUS, SHIFT_OUT.
- IDLE:
  - On i_start, latch we, size, lsb and signed.
  - Misaligned or reserved requests pulse o_err next cycle and stay in IDLE. Misaligned means half with lsb[0]=1, word with lsb≠0, or size=11.
  - Otherwise go to SHIFT_IN if i_we=1, else to BUS.
- SHIFT_IN:
  - Each cycle with i_sd_en: data[cnt] <= i_sd and cnt increments (5-bit).
  - After the bit at cnt=31 is written, cnt wraps to 0 and the FSM goes to BUS.
  - All 32 bits are always collected, whatever the size.
  - Cycles with i_sd_en low hold state.
- BUS:
  - o_wb_cyc is asserted from the first BUS cycle; o_wb_we is the latched we.
  - Select lanes: byte = 1<<lsb; half = lsb[1] ? 1100 : 0011; word = 1111. Selects are driven for loads too.
  - Write data: byte = {4{data[7:0]}}, half = {2{data[15:0]}}, word = data.
  - i_wb_ack is sampled every BUS cycle, including the first.
  - Load ack: capture i_wb_rdt >> (8*lsb) into data; cyc drops next cycle; go to SHIFT_OUT.
  - Store ack: cyc drops and o_done pulses next cycle; go to IDLE.
- SHIFT_OUT:
  - Runs exactly 32 consecutive cycles with o_ld_en=1, cnt 0..31; no stalls.
  - o_ld = data[cnt] while cnt ≤ msb, where msb = 7 for byte, 15 for half, 31 for word.
  - Above msb, o_ld = signed ? data[msb] : 0.
  - The cycle after cnt=31, o_done pulses and the FSM returns to IDLE.
- Ignored inputs: i_start outside IDLE; i_wb_ack outside BUS; i_sd_en outside SHIFT_IN.
- o_busy = (state ≠ IDLE).
- Latency:
  - Load: i_start to first o_ld_en bit = 2 cycles + ack wait.
  - Store: last i_sd_en bit to o_wb_cyc = 1 cycle.

Optional Feature:
- Macro: SERV_MEM_SERDES_TIMEOUT_EN
- Defined:
  - An 8-bit counter runs in BUS and clears on BUS entry.
  - If TO_CYCLES cycles pass without ack, drop cyc, pulse o_err (no o_done), and return to IDLE.
- Undefined: BUS waits indefinitely; the counter logic is absent.

Decomposition:
- Package serv_mem_pkg:
  - State enum (IDLE/SHIFT_IN/BUS/SHIFT_OUT).
  - Size codes (SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2).
  - msb-per-size function; sel-pattern function.
- One sub-module, serv_mem_ldser: the load serializer, holding the 32-bit register, msb compare and sign select.

Test Plan:
- Word store: i_start, we=1, size=10, lsb=0, serial 0xDEADBEEF with i_sd_en continuous, ack after 3 cycles -> o_wb_dat=0xDEADBEEF, sel=1111, we=1, o_done pulses 1 cycle after ack.
- Signed byte load: lsb=2, signed=1, i_wb_rdt=0x12_80_34_56 -> 32 serial bits reassemble to 0xFFFFFF80; o_ld_en high for exactly 32 cycles.
- Unsigned half load: lsb=2, rdt=0x8001xxxx -> 0x00008001. Then half store with 0x1234ABCD, lsb=2 -> dat=0xABCDABCD, sel=1100.
- Misalign: half with lsb=1, and word with lsb=3 -> o_err pulse, o_wb_cyc never rises, o_busy stays 0.
- Reset mid-op: assert i_rst during SHIFT_OUT at cnt=10 -> all outputs 0 immediately, no o_done; then a new load completes normally.
- Timeout (macro defined, TO_CYCLES=16): no ack -> cyc drops after 16 cycles, o_err pulses. Macro undefined: cyc is held for 100 cycles until ack.
